// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit for a MIPS subset: sequences fetch/decode/execute/writeback
// and drives the datapath mux selects, write enables and ALU operation.
module mc_control_fsm #(
  parameter int unsigned CNT_W   = 32,
  parameter bit          WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       alu_operation,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTEXEC   = 4'd6,
    S_RTWB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic             rdy;

  assign rdy           = mem_ready | ~WAIT_EN;
  assign state         = state_q;
  assign retired_count = count_q;

  // State register and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  // Next-state and output decode from the current state
  always_comb begin
    state_d       = S_FETCH;
    retire        = 1'b0;
    alu_operation = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_src        = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_en     = rdy;
        state_d   = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: state_d = S_RTEXEC;
              default: illegal = 1'b1;
            endcase
          end
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = rdy;
        i_or_d    = 1'b1;
        retire    = rdy;
        state_d   = rdy ? S_FETCH : S_MEMWR;
      end
      S_RTEXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_RTWB;
        case (funct)
          FN_SUB:  alu_operation = ALU_SUB;
          FN_AND:  alu_operation = ALU_AND;
          FN_OR:   alu_operation = ALU_OR;
          FN_NOR:  alu_operation = ALU_NOR;
          FN_SLT:  alu_operation = ALU_SLT;
          default: alu_operation = ALU_ADD;
        endcase
      end
      S_RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_operation = ALU_SUB;
        pc_src        = 2'b01;
        pc_en         = zero;
        retire        = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset overrides every architectural side effect
    if (rst) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: table of instruction vectors expanded into per-cycle
// expectations on a scoreboard queue, plus hand-written reset and wrap sequences.
module tb_mc_control_fsm;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       opcode, funct;
  logic             zero, mem_ready;
  logic [3:0]       alu_operation;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             i_or_d, mem_read, mem_write, ir_write, pc_en;
  logic [1:0]       pc_src;
  logic             reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired_count;

  mc_control_fsm #(.CNT_W(CNT_W), .WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_operation(alu_operation), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] aop;
    logic       sa;
    logic [1:0] sb;
    logic       iod;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       pce;
    logic [1:0] pcs;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       ill;
    logic [3:0] cnt;
  } obs_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        ill;
    logic [3:0]  aop;
    int          len;
    logic [31:0] seq;
  } vec_t;

  obs_t       expq[$];
  obs_t       act;
  vec_t       vecs[$];
  int         n_total = 0;
  int         n_pass  = 0;
  logic [3:0] exp_cnt = 4'd0;

  always_comb act = {state, alu_operation, alu_src_a, alu_src_b, i_or_d, mem_read,
                     mem_write, ir_write, pc_en, pc_src, reg_write, reg_dst,
                     mem_to_reg, illegal, retired_count};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  // Scoreboard: compare one expected cycle against the DUT on each falling edge
  always @(negedge clk) begin
    if (!rst && expq.size() != 0) begin
      obs_t e;
      e = expq.pop_front();
      n_total++;
      if (act === e) n_pass++;
      else $display("FAIL cycle st=%0d got=%h exp=%h", e.st, act, e);
    end
  end

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input logic ill, input logic [3:0] aop, input int len,
                              input logic [31:0] seq);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.ill = ill; v.aop = aop; v.len = len; v.seq = seq;
    return v;
  endfunction

  function automatic logic [3:0] nib(input logic [31:0] seq, input int k);
    logic [31:0] t;
    t = seq >> (28 - 4 * k);
    return t[3:0];
  endfunction

  // Expected control outputs for one state, written from the state action table
  function automatic obs_t exp_out(input logic [3:0] st, input logic rdy, input logic z,
                                   input logic [3:0] aop, input logic ill, input logic [3:0] cnt);
    obs_t e;
    e = '0;
    e.st = st; e.aop = 4'b0010; e.cnt = cnt;
    case (st)
      4'd0:  begin e.mr = 1'b1; e.sb = 2'b01; e.irw = rdy; e.pce = rdy; end
      4'd1:  begin e.sb = 2'b11; e.ill = ill; end
      4'd2:  begin e.sa = 1'b1; e.sb = 2'b10; end
      4'd3:  begin e.mr = 1'b1; e.iod = 1'b1; end
      4'd4:  begin e.rw = 1'b1; e.m2r = 1'b1; end
      4'd5:  begin e.mw = rdy; e.iod = 1'b1; end
      4'd6:  begin e.sa = 1'b1; e.aop = aop; end
      4'd7:  begin e.rw = 1'b1; e.rd = 1'b1; end
      4'd8:  begin e.sa = 1'b1; e.aop = 4'b0110; e.pcs = 2'b01; e.pce = z; end
      4'd9:  begin e.sa = 1'b1; e.sb = 2'b10; end
      4'd10: begin e.rw = 1'b1; end
      4'd11: begin e.pcs = 2'b10; e.pce = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // Drive one instruction; a memory state followed by itself in the sequence is a stall cycle
  task automatic run_vec(input vec_t v);
    for (int k = 0; k < v.len; k++) begin
      logic [3:0] st, nxt;
      logic       mem_st, rdy;
      st     = nib(v.seq, k);
      nxt    = (k + 1 < v.len) ? nib(v.seq, k + 1) : 4'd0;
      mem_st = (st == 4'd0) || (st == 4'd3) || (st == 4'd5);
      rdy    = !(mem_st && nxt == st);
      mem_ready = mem_st ? rdy : 1'($urandom_range(0, 1));
      opcode = v.op; funct = v.fn; zero = v.z;
      expq.push_back(exp_out(st, rdy, v.z, v.aop, v.ill, exp_cnt));
      if (st == 4'd4 || st == 4'd7 || st == 4'd8 || st == 4'd10 || st == 4'd11 ||
          (st == 4'd5 && rdy)) exp_cnt = exp_cnt + 4'd1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] c0;
    rst = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(retired_count), 32'd0);
    check("rst_enables", 32'({pc_en, ir_write, reg_write, mem_write, illegal}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    vecs.push_back(mk(6'h00, 6'h22, 1'b0, 1'b0, 4'b0110, 4, 32'h0167_0000));
    vecs.push_back(mk(6'h00, 6'h20, 1'b0, 1'b0, 4'b0010, 4, 32'h0167_0000));
    vecs.push_back(mk(6'h00, 6'h24, 1'b0, 1'b0, 4'b0000, 4, 32'h0167_0000));
    vecs.push_back(mk(6'h00, 6'h25, 1'b1, 1'b0, 4'b0001, 4, 32'h0167_0000));
    vecs.push_back(mk(6'h00, 6'h27, 1'b0, 1'b0, 4'b1100, 4, 32'h0167_0000));
    vecs.push_back(mk(6'h00, 6'h2A, 1'b0, 1'b0, 4'b0111, 4, 32'h0167_0000));
    vecs.push_back(mk(6'h23, 6'h00, 1'b0, 1'b0, 4'b0010, 5, 32'h0123_4000));
    vecs.push_back(mk(6'h23, 6'h11, 1'b0, 1'b0, 4'b0010, 8, 32'h0123_3334));
    vecs.push_back(mk(6'h2B, 6'h00, 1'b0, 1'b0, 4'b0010, 4, 32'h0125_0000));
    vecs.push_back(mk(6'h2B, 6'h00, 1'b0, 1'b0, 4'b0010, 5, 32'h0125_5000));
    vecs.push_back(mk(6'h08, 6'h00, 1'b0, 1'b0, 4'b0010, 5, 32'h0019_A000));
    vecs.push_back(mk(6'h04, 6'h00, 1'b1, 1'b0, 4'b0010, 3, 32'h0180_0000));
    vecs.push_back(mk(6'h04, 6'h00, 1'b0, 1'b0, 4'b0010, 3, 32'h0180_0000));
    vecs.push_back(mk(6'h02, 6'h00, 1'b0, 1'b0, 4'b0010, 3, 32'h01B0_0000));
    vecs.push_back(mk(6'h3F, 6'h00, 1'b0, 1'b1, 4'b0010, 2, 32'h0100_0000));
    vecs.push_back(mk(6'h00, 6'h03, 1'b0, 1'b1, 4'b0010, 2, 32'h0100_0000));
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted while in RTEXEC: must abort without retiring
    run_vec(mk(6'h00, 6'h22, 1'b0, 1'b0, 4'b0110, 2, 32'h0100_0000));
    check("pre_rst_rtexec", 32'(state), 32'd6);
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_count", 32'(retired_count), 32'd0);
    check("midrst_enables", 32'({pc_en, ir_write, reg_write, mem_write, illegal}), 32'd0);
    @(posedge clk); #1;
    check("midrst_hold", 32'(state), 32'd0);
    rst = 1'b0;
    exp_cnt = 4'd0;
    run_vec(mk(6'h00, 6'h20, 1'b0, 1'b0, 4'b0010, 4, 32'h0167_0000));
    check("post_rst_count", 32'(retired_count), 32'd1);

    // Sixteen jumps wrap the 4-bit counter back to its starting value
    c0 = exp_cnt;
    for (int i = 0; i < 16; i++) run_vec(mk(6'h02, 6'h00, 1'b0, 1'b0, 4'b0010, 3, 32'h01B0_0000));
    check("wrap_count", 32'(retired_count), 32'(c0));

    @(posedge clk); #1;
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
